// File: rtl/ghash_msg_sequencer_pkg.sv
// ghash_msg_sequencer_pkg: shared widths, FSM encoding and configuration check for the GHASH message sequencer
package ghash_msg_sequencer_pkg;
  localparam int NB_BLOCK = 128;
  localparam int NB_LEN = 64;
  typedef enum logic [2:0] {IDLE, AAD, TEXT, LEN, WAIT, DONE} state_t;
  function automatic logic bad_config(input int nb_block, input int n_blocks, input int log2_n, input int nb_data, input int latency);
    return nb_block != 128 || n_blocks < 2 || log2_n != $clog2(n_blocks) || nb_data != n_blocks * nb_block || latency < 0;
  endfunction
endpackage

// File: rtl/ghash_block_padder.sv
// ghash_block_padder: zeroes unused blocks and the unused tail bits of a section's final word
module ghash_block_padder
  import ghash_msg_sequencer_pkg::*;
#(
  parameter int N_BLOCKS = 2,
  parameter int LOG2_N_BLOCKS = 1,
  parameter int NB_DATA = N_BLOCKS * NB_BLOCK
) (
  input  logic [NB_DATA-1:0]     data,
  input  logic                   last,
  input  logic [LOG2_N_BLOCKS:0] nvalid,
  input  logic [6:0]             resid,
  output logic [NB_DATA-1:0]     data_out,
  output logic [N_BLOCKS-1:0]    skip
);
  localparam logic [NB_BLOCK-1:0] ONES = '1;
  for (genvar b = 0; b < N_BLOCKS; b++) begin : g_blk
    localparam logic [LOG2_N_BLOCKS:0] IDX = (LOG2_N_BLOCKS + 1)'(b);
    localparam logic [LOG2_N_BLOCKS:0] NXT = (LOG2_N_BLOCKS + 1)'(b + 1);
    logic tail;
    assign skip[b] = last && IDX >= nvalid;
    assign tail = last && NXT == nvalid && |resid;
    assign data_out[b*NB_BLOCK +: NB_BLOCK] = skip[b] ? '0 :
      tail ? data[b*NB_BLOCK +: NB_BLOCK] & ~(ONES >> resid) : data[b*NB_BLOCK +: NB_BLOCK];
  end
endmodule

// File: rtl/ghash_msg_sequencer.sv
// ghash_msg_sequencer: feeds one GCM message (AAD, text, length block) through an N-block GHASH and captures the tag
module ghash_msg_sequencer #(
  parameter int NB_BLOCK = 128,
  parameter int N_BLOCKS = 2,
  parameter int LOG2_N_BLOCKS = 1,
  parameter int NB_DATA = N_BLOCKS * NB_BLOCK,
  parameter int NB_LEN = 64,
  parameter int GHASH_LATENCY = 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_LEN-1:0]   i_aad_len,
  input  logic [NB_LEN-1:0]   i_text_len,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [NB_DATA-1:0]  o_ghash_data_bus,
  output logic [NB_BLOCK-1:0] o_ghash_x_initial,
  output logic                o_ghash_sop,
  output logic                o_ghash_valid,
  output logic [N_BLOCKS-1:0] o_ghash_skip_bus,
  input  logic [NB_BLOCK-1:0] i_ghash_y,
  output logic [NB_BLOCK-1:0] o_tag,
  output logic                o_tag_valid,
  output logic                o_busy
);
  import ghash_msg_sequencer_pkg::*;
  localparam int NB_CNT = NB_LEN - 7;
  localparam int NB_WAIT = $clog2(GHASH_LATENCY + 1) + 1;
  if (bad_config(NB_BLOCK, N_BLOCKS, LOG2_N_BLOCKS, NB_DATA, GHASH_LATENCY)) begin : g_bad_config
    $error("ghash_msg_sequencer: bad configuration");
  end
  function automatic logic [NB_CNT-1:0] blocks(input logic [NB_LEN-1:0] len);
    return len[NB_LEN-1:7] + NB_CNT'(|len[6:0]);
  endfunction
  state_t state, state_nx;
  logic [NB_LEN-1:0] aad_len, text_len;
  logic [NB_CNT-1:0] rem, rem_nx, n_aad_in, n_text_in, n_text;
  logic [NB_WAIT-1:0] wcnt;
  logic sop_pending, accept, issue, last, capture;
  logic [NB_DATA-1:0] pad_data;
  logic [N_BLOCKS-1:0] pad_skip;
  assign n_aad_in = blocks(i_aad_len);
  assign n_text_in = blocks(i_text_len);
  assign n_text = blocks(text_len);
  assign o_ready = state == AAD || state == TEXT;
  assign accept = o_ready && i_valid;
  assign issue = accept || state == LEN;
  assign last = rem <= NB_CNT'(N_BLOCKS);
  assign capture = state == WAIT && wcnt == NB_WAIT'(GHASH_LATENCY);
  assign o_ghash_x_initial = '0;
  assign o_tag_valid = state == DONE;
  assign o_busy = state != IDLE;
  ghash_block_padder #(
    .N_BLOCKS(N_BLOCKS),
    .LOG2_N_BLOCKS(LOG2_N_BLOCKS),
    .NB_DATA(NB_DATA)
  ) u_padder (
    .data(i_data),
    .last(last),
    .nvalid(rem[LOG2_N_BLOCKS:0]),
    .resid(state == AAD ? aad_len[6:0] : text_len[6:0]),
    .data_out(pad_data),
    .skip(pad_skip)
  );
  always_comb begin
    state_nx = state;
    rem_nx = rem;
    case (state)
      IDLE: if (i_start) begin
        state_nx = |n_aad_in ? AAD : |n_text_in ? TEXT : LEN;
        rem_nx = |n_aad_in ? n_aad_in : n_text_in;
      end
      AAD: if (accept) begin
        state_nx = !last ? AAD : |n_text ? TEXT : LEN;
        rem_nx = last ? n_text : rem - NB_CNT'(N_BLOCKS);
      end
      TEXT: if (accept) begin
        state_nx = last ? LEN : TEXT;
        rem_nx = rem - NB_CNT'(N_BLOCKS);
      end
      LEN: state_nx = WAIT;
      WAIT: state_nx = capture ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      rem <= '0;
      aad_len <= '0;
      text_len <= '0;
      wcnt <= '0;
      sop_pending <= 1'b0;
      o_ghash_valid <= 1'b0;
      o_ghash_sop <= 1'b0;
      o_ghash_data_bus <= '0;
      o_ghash_skip_bus <= '0;
      o_tag <= '0;
    end else begin
      state <= state_nx;
      rem <= rem_nx;
      if (state == IDLE && i_start) begin
        aad_len <= i_aad_len;
        text_len <= i_text_len;
      end
      sop_pending <= (state == IDLE && i_start) || (sop_pending && !issue);
      o_ghash_valid <= issue;
      o_ghash_sop <= issue && sop_pending;
      o_ghash_data_bus <= state == LEN ? NB_DATA'({aad_len, text_len}) : pad_data;
      o_ghash_skip_bus <= state == LEN ? ~N_BLOCKS'(1) : pad_skip;
      wcnt <= state == WAIT ? wcnt + NB_WAIT'(1) : '0;
      if (capture) o_tag <= i_ghash_y;
    end
  end
endmodule

// File: tb/tb_ghash_msg_sequencer.sv
// tb_ghash_msg_sequencer: randomized message bench with a GHASH datapath model and a block-level reference
module tb_ghash_msg_sequencer;
  localparam int N = 2;
  localparam int LAT = 1;
  typedef struct {
    logic [255:0] data;
    logic [1:0]   skip;
    logic         sop;
    logic         is_len;
  } word_t;
  logic i_clock = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_valid = 1'b0;
  logic [63:0] i_aad_len = '0, i_text_len = '0;
  logic [255:0] i_data = '0;
  logic o_ready, o_ghash_sop, o_ghash_valid, o_tag_valid, o_busy;
  logic [255:0] o_ghash_data_bus;
  logic [127:0] o_ghash_x_initial, o_tag, i_ghash_y;
  logic [1:0] o_ghash_skip_bus;
  logic [127:0] ghash_y = '0, hkey, exp_tag, tag1;
  logic acc_d = 1'b0;
  logic [63:0] msg_aad, msg_text;
  word_t exp_words[$], exp_q[$];
  logic [255:0] in_words[$];
  int total = 0, bad = 0, cyc = 0, len_cyc = 0, tag_seen = 0;
  bit tag_armed = 0;

  ghash_msg_sequencer #(.N_BLOCKS(N), .GHASH_LATENCY(LAT)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
    .i_aad_len(i_aad_len), .i_text_len(i_text_len),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_ghash_data_bus(o_ghash_data_bus), .o_ghash_x_initial(o_ghash_x_initial),
    .o_ghash_sop(o_ghash_sop), .o_ghash_valid(o_ghash_valid),
    .o_ghash_skip_bus(o_ghash_skip_bus), .i_ghash_y(i_ghash_y),
    .o_tag(o_tag), .o_tag_valid(o_tag_valid), .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [127:0] gfmul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? (v >> 1) ^ {8'he1, 120'h0} : v >> 1;
    end
    return z;
  endfunction

  function automatic logic [127:0] fold(input logic [127:0] y0, input logic [255:0] d, input logic [1:0] s);
    logic [127:0] y;
    y = y0;
    for (int b = 0; b < N; b++) if (!s[b]) y = gfmul(y ^ d[b*128 +: 128], hkey);
    return y;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // GHASH datapath stand-in with one register stage
  assign i_ghash_y = ghash_y;
  always @(posedge i_clock) if (o_ghash_valid) ghash_y <= fold(o_ghash_sop ? o_ghash_x_initial : ghash_y, o_ghash_data_bus, o_ghash_skip_bus);
  always @(posedge i_clock) acc_d <= i_valid && o_ready;

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  initial begin
    word_t e;
    forever begin
      @(negedge i_clock);
      cyc++;
      if (o_ghash_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("word_data", o_ghash_data_bus, e.data);
          chk("word_skip", o_ghash_skip_bus, e.skip);
          chk("word_sop", o_ghash_sop, e.sop);
          chk("word_source", acc_d | e.is_len, 1);
          if (e.is_len) len_cyc = cyc;
        end
      end
      if (acc_d === 1'b1) chk("valid_after_accept", o_ghash_valid, 1);
      if (o_tag_valid === 1'b1) begin
        chk("tag_expected", tag_armed, 1);
        chk("tag_value", o_tag, exp_tag);
        chk("tag_latency", cyc - len_cyc, LAT + 1);
        tag_armed = 0;
        tag_seen++;
      end
    end
  end

  task automatic build_msg(input logic [63:0] al, input logic [63:0] tl);
    logic [127:0] y, blk, ones;
    logic [255:0] raw;
    logic [63:0] lens[2];
    logic first;
    word_t e;
    int n, r, k;
    y = '0;
    ones = '1;
    first = 1;
    lens[0] = al;
    lens[1] = tl;
    msg_aad = al;
    msg_text = tl;
    in_words.delete();
    exp_words.delete();
    for (int s = 0; s < 2; s++) begin
      n = int'((lens[s] + 127) / 128);
      r = int'(lens[s] % 128);
      for (int w = 0; w * N < n; w++) begin
        raw = rnd256();
        e.data = '0;
        e.skip = '0;
        e.sop = first;
        e.is_len = 0;
        first = 0;
        for (int b = 0; b < N; b++) begin
          k = w * N + b;
          blk = raw[b*128 +: 128];
          if (k >= n) e.skip[b] = 1'b1;
          else begin
            if (k == n - 1 && r != 0) blk = blk & (ones << (128 - r));
            e.data[b*128 +: 128] = blk;
            y = gfmul(y ^ blk, hkey);
          end
        end
        in_words.push_back(raw);
        exp_words.push_back(e);
      end
    end
    e.data = {128'h0, al, tl};
    e.skip = 2'b10;
    e.sop = first;
    e.is_len = 1;
    exp_words.push_back(e);
    exp_tag = gfmul(y ^ {al, tl}, hkey);
  endtask

  task automatic feed_word(input logic [255:0] d, input bit gaps, input bit mid);
    int k;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      i_valid = 0;
      i_data = rnd256();
      i_start = mid && $urandom_range(0, 1) == 1;
      i_aad_len = {32'h0, $urandom};
      i_text_len = {32'h0, $urandom};
      @(negedge i_clock);
    end
    i_start = 0;
    i_valid = 1;
    i_data = d;
    k = 0;
    while (!o_ready && k < 50) begin
      @(negedge i_clock);
      k++;
    end
    chk("ready_wait", k < 50, 1);
    @(negedge i_clock);
    i_valid = 0;
  endtask

  task automatic start_msg();
    exp_q = exp_words;
    tag_armed = 1;
    i_aad_len = msg_aad;
    i_text_len = msg_text;
    i_start = 1;
    @(negedge i_clock);
    i_start = 0;
    chk("busy_after_start", o_busy, 1);
  endtask

  task automatic run_msg(input bit gaps, input bit mid);
    int k, snap;
    snap = tag_seen;
    start_msg();
    foreach (in_words[i]) feed_word(in_words[i], gaps, mid);
    k = 0;
    while (tag_seen == snap && k < 100) begin
      @(negedge i_clock);
      k++;
    end
    chk("tag_pulse_count", tag_seen - snap, 1);
    @(negedge i_clock);
    chk("busy_idle", o_busy, 0);
    chk("ready_idle", o_ready, 0);
    chk("words_drained", exp_q.size(), 0);
  endtask

  initial begin
    hkey = {$urandom, $urandom, $urandom, $urandom | 32'h1};
    repeat (2) @(negedge i_clock);
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", o_ghash_valid, 0);
    chk("rst_sop", o_ghash_sop, 0);
    chk("rst_skip", o_ghash_skip_bus, 0);
    chk("rst_data", o_ghash_data_bus, 0);
    chk("rst_xinit", o_ghash_x_initial, 0);
    chk("rst_tag", o_tag, 0);
    chk("rst_tag_valid", o_tag_valid, 0);
    chk("rst_busy", o_busy, 0);
    i_reset = 0;
    @(negedge i_clock);
    build_msg(256, 256);
    run_msg(0, 0);
    build_msg(0, 384);
    run_msg(0, 0);
    build_msg(100, 128);
    run_msg(0, 0);
    build_msg(0, 0);
    run_msg(0, 0);
    build_msg(300, 500);
    run_msg(0, 0);
    tag1 = o_tag;
    run_msg(1, 1);
    chk("tag_vs_gapfree", o_tag, tag1);
    repeat (5) @(negedge i_clock);
    chk("tag_hold", o_tag, exp_tag);
    repeat (6) begin
      build_msg(64'($urandom_range(0, 700)), 64'($urandom_range(0, 700)));
      run_msg(1, 0);
    end
    build_msg(128, 512);
    start_msg();
    feed_word(in_words[0], 0, 0);
    feed_word(in_words[1], 0, 0);
    chk("abort_in_text", o_ready, 1);
    tag_armed = 0;
    i_reset = 1;
    @(posedge i_clock);
    #1 exp_q.delete();
    @(negedge i_clock);
    i_reset = 0;
    chk("abort_ready", o_ready, 0);
    chk("abort_valid", o_ghash_valid, 0);
    chk("abort_busy", o_busy, 0);
    repeat (10) @(negedge i_clock);
    build_msg(200, 300);
    run_msg(1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
